axi_ram_responder: RTL and testbench
====================================

// Module: axi_ram_responder
// PURPOSE
//  AXI slave that answers frame-buffer write/read bursts from an on-chip RAM: the memory side of the DDR port.
//  Replaces the DDR controller in standalone bring-up and simulation; one burst in flight per direction.
// PARAMETERS
//  AXI_ID_WIDTH    8    ID width on AW/B/AR/R
//  AXI_ADDR_WIDTH  32   byte address width
//  AXI_DATA_WIDTH  256  data width, power of 2; NB = AXI_DATA_WIDTH/8, LSB = log2(NB)
//  MEM_AW          10   RAM word-address width; depth = 2**MEM_AW words of AXI_DATA_WIDTH
// PORTS
//  axi_clk      in   1               sole clock
//  rst_n        in   1               async active-low reset
//  axi_awid     in   AXI_ID_WIDTH    write burst ID
//  axi_awaddr   in   AXI_ADDR_WIDTH  write start byte address
//  axi_awlen    in   8               beats-1
//  axi_awburst  in   2               00 FIXED, else INCR
//  axi_awvalid  in   1               AW valid
//  axi_awready  out  1               AW ready
//  axi_wdata    in   AXI_DATA_WIDTH  write data
//  axi_wstrb    in   NB              byte enables
//  axi_wlast    in   1               last write beat
//  axi_wvalid   in   1               W valid
//  axi_wready   out  1               W ready
//  axi_bid      out  AXI_ID_WIDTH    = captured awid
//  axi_bresp    out  2               00 OKAY, 10 SLVERR
//  axi_bvalid   out  1               B valid
//  axi_bready   in   1               B ready
//  axi_arid     in   AXI_ID_WIDTH    read burst ID
//  axi_araddr   in   AXI_ADDR_WIDTH  read start byte address
//  axi_arlen    in   8               beats-1
//  axi_arburst  in   2               00 FIXED, else INCR
//  axi_arvalid  in   1               AR valid
//  axi_arready  out  1               AR ready
//  axi_rid      out  AXI_ID_WIDTH    = captured arid
//  axi_rdata    out  AXI_DATA_WIDTH  read data
//  axi_rresp    out  2               always 00
//  axi_rlast    out  1               last read beat
//  axi_rvalid   out  1               R valid
//  axi_rready   in   1               R ready
// BEHAVIOUR
//  Reset: every output 0, both FSMs idle; RAM contents not cleared. Reset mid-burst aborts it silently.
//  Word index = addr[LSB +: MEM_AW]; upper bits ignored; INCR adds 1 per beat, wraps 2**MEM_AW-1 -> 0; FIXED holds.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; AW handshake latches id/index/len/burst, beat cnt=0, err=0.
//   W_DATA: wready=1; each W handshake writes bytes with wstrb=1, advances index/cnt; err|=(wlast!=(cnt==len)).
//   Beat cnt==len ends burst regardless of wlast. W_RESP: bvalid=1, bresp=err?10:00, held until bready; then idle (awready next cycle).
//  Read FSM R_IDLE->R_DATA->R_IDLE. R_IDLE: arready=1; AR handshake latches id/len/burst, loads rdata<=RAM[index].
//   R_DATA: rvalid=1 from cycle after AR handshake; rlast=(cnt==len); on R handshake not last, rdata<=next word same edge (1 beat/clk).
//   rvalid/rdata/rlast stable while rready=0. Last handshake -> R_IDLE, rvalid=0.
//  FSMs independent; read and write same word same cycle: read returns old data.
// TESTING
//  AW id 0xA0 addr 0x40 len 3, 4 beats D0..D3 strb all-1 -> bid 0xA0, bresp 00; AR same -> D0..D3 on 4 consecutive cycles, rlast on 4th.
//  Write wstrb=0x0000000F over 0 word -> read shows only bytes 0-3 changed.
//  INCR len 3 at word 2**MEM_AW-2 -> words 1022,1023,0,1 written; read-back matches.
//  wlast on beat 2 of len 3 -> 4 beats accepted, bresp 10; rready toggled 0/1 -> no lost or repeated beat.
//  Concurrent 8-beat write and read, different regions -> both complete, data correct; rst_n low mid-burst -> all valid/ready 0, idle after release.

Source files
------------

// File: rtl/axi_ram_responder.sv
// AXI slave backed by on-chip RAM, one burst in flight per direction; all outputs registered.
// R data 1 clk after AR handshake, 1 beat/clk; W/R stall on wvalid/rready, B and R beats held until accepted.
module axi_ram_responder #(
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int MEM_AW         = 10
) (
  input  logic                        axi_clk,
  input  logic                        rst_n,
  input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic [1:0]                  axi_awburst,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wlast,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                  axi_arlen,
  input  logic [1:0]                  axi_arburst,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rlast,
  output logic                        axi_rvalid,
  input  logic                        axi_rready
);

  localparam int NB  = AXI_DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [AXI_DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  // Only the word-index bits of the addresses are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[AXI_ADDR_WIDTH-1:LSB+MEM_AW], axi_awaddr[LSB-1:0],
                              axi_araddr[AXI_ADDR_WIDTH-1:LSB+MEM_AW], axi_araddr[LSB-1:0]};

  logic [1:0]              w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [MEM_AW-1:0]       w_idx_q, w_idx_d;
  logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                    w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    w_fire, w_last_beat, w_err_beat;

  assign w_fire      = wready_q & axi_wvalid;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_err_beat  = (axi_wlast != w_last_beat);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && axi_awvalid) begin
          w_id_d    = axi_awid;
          w_idx_d   = axi_awaddr[LSB +: MEM_AW];
          w_len_d   = axi_awlen;
          w_fixed_d = (axi_awburst == 2'b00);
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_err_d = w_err_q | w_err_beat;
          // Beat count alone terminates the burst; a misplaced wlast only flags SLVERR.
          if (w_last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (w_err_q | w_err_beat) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + IDX_ONE;
          end
        end
      end
      W_RESP: begin
        if (axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (w_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
  end

  logic [0:0]                r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [MEM_AW-1:0]         r_idx_q, r_idx_d, r_load_idx;
  logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                      r_fixed_q, r_fixed_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                      r_load;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  // r_idx_q always points at the word to fetch for the following beat.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_fixed_d  = r_fixed_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    r_load     = 1'b0;
    r_load_idx = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && axi_arvalid) begin
          r_id_d     = axi_arid;
          r_len_d    = axi_arlen;
          r_fixed_d  = (axi_arburst == 2'b00);
          r_cnt_d    = 8'd0;
          r_load     = 1'b1;
          r_load_idx = axi_araddr[LSB +: MEM_AW];
          r_idx_d    = (axi_arburst == 2'b00) ? axi_araddr[LSB +: MEM_AW]
                                              : axi_araddr[LSB +: MEM_AW] + IDX_ONE;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rlast_d    = (axi_arlen == 8'd0);
          r_state_d  = R_DATA;
        end
      end
      default: begin
        if (axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_load  = 1'b1;
            r_idx_d = r_fixed_q ? r_idx_q : r_idx_q + IDX_ONE;
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      if (r_load) rdata_q <= mem[r_load_idx];
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_bid     = w_id_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rdata   = rdata_q;
  assign axi_rid     = r_id_q;
  assign axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder against an array-based memory model.
module tb_axi_ram_responder;
  localparam int IDW = 8, ADW = 32, DW = 256, NB = 32, MAW = 10, DEPTH = 1024;

  logic           axi_clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IDW-1:0] axi_awid = '0;
  logic [ADW-1:0] axi_awaddr = '0;
  logic [7:0]     axi_awlen = '0;
  logic [1:0]     axi_awburst = '0;
  logic           axi_awvalid = 1'b0;
  logic           axi_awready;
  logic [DW-1:0]  axi_wdata = '0;
  logic [NB-1:0]  axi_wstrb = '0;
  logic           axi_wlast = 1'b0;
  logic           axi_wvalid = 1'b0;
  logic           axi_wready;
  logic [IDW-1:0] axi_bid;
  logic [1:0]     axi_bresp;
  logic           axi_bvalid;
  logic           axi_bready = 1'b0;
  logic [IDW-1:0] axi_arid = '0;
  logic [ADW-1:0] axi_araddr = '0;
  logic [7:0]     axi_arlen = '0;
  logic [1:0]     axi_arburst = '0;
  logic           axi_arvalid = 1'b0;
  logic           axi_arready;
  logic [IDW-1:0] axi_rid;
  logic [DW-1:0]  axi_rdata;
  logic [1:0]     axi_rresp;
  logic           axi_rlast;
  logic           axi_rvalid;
  logic           axi_rready = 1'b0;

  axi_ram_responder #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(ADW), .AXI_DATA_WIDTH(DW), .MEM_AW(MAW)) dut (
    .axi_clk(axi_clk), .rst_n(rst_n),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 axi_clk = ~axi_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic int word_of(input logic [ADW-1:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  function automatic int beat_word(input logic [ADW-1:0] a, input int k, input logic [1:0] burst);
    return (burst == 2'b00) ? word_of(a) : (word_of(a) + k) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // last_at < 0: wlast on the true last beat; otherwise wlast only on beat last_at.
  task automatic wr_burst(input logic [7:0] id, input logic [ADW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [NB-1:0] strb, input int last_at,
                          input string tag);
    int  budget;
    int  w;
    bit  bad;
    bad = 1'b0;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
    budget = 0;
    while (!axi_awready && budget < 200) begin cyc(); budget++; end
    if (!axi_awready) begin chk({tag, "_aw_timeout"}, 0, 1); axi_awvalid = 1'b0; return; end
    cyc();
    axi_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      axi_wdata  = rand_word();
      axi_wstrb  = strb;
      axi_wlast  = (last_at < 0) ? (k == int'(len)) : (k == last_at);
      axi_wvalid = 1'b1;
      if (axi_wlast != (k == int'(len))) bad = 1'b1;
      budget = 0;
      while (!axi_wready && budget < 200) begin cyc(); budget++; end
      if (!axi_wready) begin chk({tag, "_w_timeout"}, 0, 1); axi_wvalid = 1'b0; return; end
      w = beat_word(addr, k, burst);
      for (int b = 0; b < NB; b++) if (strb[b]) ref_mem[w][b*8 +: 8] = axi_wdata[b*8 +: 8];
      cyc();
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
      if (k < int'(len)) repeat ($urandom_range(0, 1)) cyc();
    end
    chk({tag, "_wready_done"}, axi_wready, 0);
    repeat ($urandom_range(0, 2)) cyc();
    axi_bready = 1'b1;
    budget = 0;
    while (!axi_bvalid && budget < 200) begin cyc(); budget++; end
    if (!axi_bvalid) begin chk({tag, "_b_timeout"}, 0, 1); axi_bready = 1'b0; return; end
    chk({tag, "_bid"}, axi_bid, id);
    chk({tag, "_bresp"}, axi_bresp, bad ? 2'b10 : 2'b00);
    cyc();
    axi_bready = 1'b0;
    chk({tag, "_bvalid_drop"}, axi_bvalid, 0);
    chk({tag, "_awready_back"}, axi_awready, 1);
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [ADW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall, input string tag);
    int            budget;
    int            k;
    bit            held;
    logic [DW-1:0] hold;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1;
    budget = 0;
    while (!axi_arready && budget < 200) begin cyc(); budget++; end
    if (!axi_arready) begin chk({tag, "_ar_timeout"}, 0, 1); axi_arvalid = 1'b0; return; end
    cyc();
    axi_arvalid = 1'b0;
    chk({tag, "_rvalid_first"}, axi_rvalid, 1);
    k = 0; budget = 0; held = 1'b0; hold = '0;
    while (k <= int'(len) && budget < 2000) begin
      axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin chk({tag, "_hold"}, axi_rdata, hold); held = 1'b0; end
      if (!stall) chk({tag, "_rvalid_b2b"}, axi_rvalid, 1);
      if (axi_rvalid && axi_rready) begin
        chk({tag, "_rdata"}, axi_rdata, ref_mem[beat_word(addr, k, burst)]);
        chk({tag, "_rlast"}, axi_rlast, k == int'(len));
        chk({tag, "_rid"}, axi_rid, id);
        k++;
      end else if (axi_rvalid) begin
        hold = axi_rdata;
        held = 1'b1;
      end
      cyc();
      budget++;
    end
    axi_rready = 1'b0;
    if (k <= int'(len)) chk({tag, "_r_timeout"}, k, int'(len) + 1);
    chk({tag, "_rvalid_end"}, axi_rvalid, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            la;
    logic [7:0]    len;
    logic [ADW-1:0] addr;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_awready", axi_awready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_arready", axi_arready, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_awready", axi_awready, 1);
    chk("idle_arready", axi_arready, 1);

    for (int i = 0; i < 4; i++)
      wr_burst(8'(i), ADW'(i * 256 * 32), 8'd255, 2'b01, '1, -1, "fill");

    wr_burst(8'hA0, 32'h40, 8'd3, 2'b01, '1, -1, "basic_wr");
    rd_burst(8'hA0, 32'h40, 8'd3, 2'b01, 1'b0, "basic_rd");

    wr_burst(8'h11, 32'h0, 8'd0, 2'b01, 32'h0000000F, -1, "strb_wr");
    rd_burst(8'h12, 32'h0, 8'd0, 2'b01, 1'b0, "strb_rd");

    wr_burst(8'h21, ADW'((DEPTH - 2) * 32), 8'd3, 2'b01, '1, -1, "wrap_wr");
    rd_burst(8'h22, ADW'((DEPTH - 2) * 32), 8'd3, 2'b01, 1'b0, "wrap_rd");
    rd_burst(8'h23, 32'h0, 8'd1, 2'b01, 1'b1, "wrap_lo_rd");

    wr_burst(8'h31, ADW'(500 * 32), 8'd3, 2'b00, 32'hF0F0_00FF, -1, "fixed_wr");
    rd_burst(8'h32, ADW'(500 * 32), 8'd2, 2'b00, 1'b0, "fixed_rd");

    wr_burst(8'h41, ADW'(40 * 32), 8'd3, 2'b01, '1, 1, "early_last_wr");
    rd_burst(8'h42, ADW'(40 * 32), 8'd3, 2'b01, 1'b1, "early_last_rd");

    fork
      wr_burst(8'h51, ADW'(100 * 32), 8'd7, 2'b01, '1, -1, "conc_wr");
      rd_burst(8'h52, ADW'(600 * 32), 8'd7, 2'b01, 1'b1, "conc_rd");
    join
    rd_burst(8'h53, ADW'(100 * 32), 8'd7, 2'b01, 1'b0, "conc_chk");

    for (int it = 0; it < 20; it++) begin
      addr = $urandom;
      len  = 8'($urandom_range(0, 15));
      la   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len) + 1) : -1;
      wr_burst(8'($urandom), addr, len, 2'($urandom_range(0, 3)), NB'($urandom), la, "rand_wr");
      rd_burst(8'($urandom), addr, len, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand_rd");
    end

    // Abort a write and a read mid-burst with reset.
    axi_awid = 8'h61; axi_awaddr = ADW'(300 * 32); axi_awlen = 8'd7; axi_awburst = 2'b01; axi_awvalid = 1'b1;
    axi_arid = 8'h62; axi_araddr = ADW'(700 * 32); axi_arlen = 8'd7; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    chk("abort_awready", axi_awready, 1);
    cyc();
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi_wdata = rand_word(); axi_wstrb = '1; axi_wvalid = 1'b1;
      chk("abort_wready", axi_wready, 1);
      ref_mem[300 + k] = axi_wdata;
      cyc();
    end
    axi_wvalid = 1'b0;
    chk("abort_rvalid_pre", axi_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_awready", axi_awready, 0);
    chk("abort_rst_wready", axi_wready, 0);
    chk("abort_rst_bvalid", axi_bvalid, 0);
    chk("abort_rst_arready", axi_arready, 0);
    chk("abort_rst_rvalid", axi_rvalid, 0);
    chk("abort_rst_rlast", axi_rlast, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("abort_idle_awready", axi_awready, 1);
    chk("abort_idle_arready", axi_arready, 1);
    chk("abort_idle_wready", axi_wready, 0);
    chk("abort_idle_rvalid", axi_rvalid, 0);
    rd_burst(8'h63, ADW'(300 * 32), 8'd7, 2'b01, 1'b0, "abort_rd");
    wr_burst(8'h64, ADW'(700 * 32), 8'd2, 2'b01, '1, -1, "post_wr");
    rd_burst(8'h65, ADW'(700 * 32), 8'd2, 2'b01, 1'b1, "post_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
